// File: rtl/rr_pkt_arb.sv
// rr_pkt_arb: packet-granular round-robin merge of two 64-bit AXI4-Stream
// receive streams (A, D) into one stream through a registered output stage.
//
// Ports:
//   clk, arst                 clock, async active-high reset
//   s_axis_A_*                port A slave stream (tdata/tstrb/tuser/tvalid/tlast/tready)
//   s_axis_D_*                port D slave stream (same shape as A)
//   m_axis_*                  merged master stream, all outputs registered
//   pkt_cnt_A, pkt_cnt_D      packets forwarded per port
//
// Build option: define RR_PKT_ARB_STATS_EN to instantiate the per-port packet
// counters (CNT_W bits, wrapping). Without it both counters read as zero.

module rr_pkt_arb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst,

   input  logic [63:0]      s_axis_A_tdata,
   input  logic [7:0]       s_axis_A_tstrb,
   input  logic [127:0]     s_axis_A_tuser,
   input  logic             s_axis_A_tvalid,
   input  logic             s_axis_A_tlast,
   output logic             s_axis_A_tready,

   input  logic [63:0]      s_axis_D_tdata,
   input  logic [7:0]       s_axis_D_tstrb,
   input  logic [127:0]     s_axis_D_tuser,
   input  logic             s_axis_D_tvalid,
   input  logic             s_axis_D_tlast,
   output logic             s_axis_D_tready,

   output logic [63:0]      m_axis_tdata,
   output logic [7:0]       m_axis_tstrb,
   output logic [127:0]     m_axis_tuser,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   input  logic             m_axis_tready,

   output logic [CNT_W-1:0] pkt_cnt_A,
   output logic [CNT_W-1:0] pkt_cnt_D
);

   typedef enum logic [1:0] {
      IDLE,
      GNT_A,
      GNT_D
   } state_t;

   state_t state;
   logic   turn;
   logic   out_free;
   logic   acc_a;
   logic   acc_d;

   // The output register can take a beat when empty or draining this cycle.
   // Ready never looks at the slave tvalid, so there is no valid->ready path.
   assign out_free        = !m_axis_tvalid || m_axis_tready;
   assign s_axis_A_tready = (state == GNT_A) && out_free;
   assign s_axis_D_tready = (state == GNT_D) && out_free;

   assign acc_a = s_axis_A_tvalid && s_axis_A_tready;
   assign acc_d = s_axis_D_tvalid && s_axis_D_tready;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= IDLE;
         turn          <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               // turn = 0 lets A win a tie, turn = 1 lets D win.
               if (s_axis_A_tvalid && (!s_axis_D_tvalid || !turn)) begin
                  state <= GNT_A;
                  turn  <= 1'b1;
               end else if (s_axis_D_tvalid) begin
                  state <= GNT_D;
                  turn  <= 1'b0;
               end
            end
            GNT_A: begin
               if (acc_a && s_axis_A_tlast)
                  state <= IDLE;
            end
            GNT_D: begin
               if (acc_d && s_axis_D_tlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         unique case (1'b1)
            acc_a: begin
               m_axis_tvalid <= 1'b1;
               m_axis_tlast  <= s_axis_A_tlast;
               m_axis_tdata  <= s_axis_A_tdata;
               m_axis_tstrb  <= s_axis_A_tstrb;
               m_axis_tuser  <= s_axis_A_tuser;
            end
            acc_d: begin
               m_axis_tvalid <= 1'b1;
               m_axis_tlast  <= s_axis_D_tlast;
               m_axis_tdata  <= s_axis_D_tdata;
               m_axis_tstrb  <= s_axis_D_tstrb;
               m_axis_tuser  <= s_axis_D_tuser;
            end
            default: begin
               // Payload stays put; only the valid flag drops once consumed.
               if (m_axis_tready)
                  m_axis_tvalid <= 1'b0;
            end
         endcase
      end
   end

`ifdef RR_PKT_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_a <= '0;
         cnt_d <= '0;
      end else begin
         if (acc_a && s_axis_A_tlast)
            cnt_a <= cnt_a + 1'b1;
         if (acc_d && s_axis_D_tlast)
            cnt_d <= cnt_d + 1'b1;
      end
   end

   assign pkt_cnt_A = cnt_a;
   assign pkt_cnt_D = cnt_d;
`else
   assign pkt_cnt_A = '0;
   assign pkt_cnt_D = '0;
`endif

endmodule

// File: tb/tb_rr_pkt_arb.sv
// tb_rr_pkt_arb: directed and randomized bench for rr_pkt_arb.
// Sources and sink are driven on the falling edge; a per-port packet scoreboard checks the merged stream.

module tb_rr_pkt_arb;

   localparam int CNT_W = 32;
`ifdef RR_PKT_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst = 1'b1;

   logic             sv [2];
   logic [63:0]      sd [2];
   logic [7:0]       ss [2];
   logic [127:0]     su [2];
   logic             sl [2];
   logic             a_rdy;
   logic             d_rdy;
   logic [63:0]      m_tdata;
   logic [7:0]       m_tstrb;
   logic [127:0]     m_tuser;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_d;
   logic [200:0]     out_vec;

   always #5 clk = ~clk;

   assign out_vec = {m_tlast, m_tuser, m_tstrb, m_tdata};

   rr_pkt_arb #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .arst            (arst),
      .s_axis_A_tdata  (sd[0]),
      .s_axis_A_tstrb  (ss[0]),
      .s_axis_A_tuser  (su[0]),
      .s_axis_A_tvalid (sv[0]),
      .s_axis_A_tlast  (sl[0]),
      .s_axis_A_tready (a_rdy),
      .s_axis_D_tdata  (sd[1]),
      .s_axis_D_tstrb  (ss[1]),
      .s_axis_D_tuser  (su[1]),
      .s_axis_D_tvalid (sv[1]),
      .s_axis_D_tlast  (sl[1]),
      .s_axis_D_tready (d_rdy),
      .m_axis_tdata    (m_tdata),
      .m_axis_tstrb    (m_tstrb),
      .m_axis_tuser    (m_tuser),
      .m_axis_tvalid   (m_tvalid),
      .m_axis_tlast    (m_tlast),
      .m_axis_tready   (m_tready),
      .pkt_cnt_A       (cnt_a),
      .pkt_cnt_D       (cnt_d)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Source configuration/state, index 0 = A, 1 = D.
   int en [2];
   int npkts [2];
   int plen [2];
   int bidx [2];
   int curlen [2];
   int gap [2];
   int vpct [2];
   int fga [2];
   int fgl [2];
   int tr_mode;

   // Reference model: expected beats per port, packets seen per port.
   logic [200:0] qa [$];
   logic [200:0] qd [$];
   int           out_order [$];
   int           sb_pkts [2];
   int           tot_beats;
   int           pkt_beats;
   bit           in_pkt;
   int           cur_p;
   int           last_end;
   int           prev_xfer;
   bit           gap_chk;
   bit           t5_mode;
   logic         stalled_prev;
   logic [200:0] prev_out;
   logic         hs_a;
   logic         hs_d;
   logic         hs_m;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_gap(input int p);
      if ($urandom_range(0, 99) < vpct[p])
         return 0;
      return $urandom_range(1, 3);
   endfunction

   task automatic new_beat(input int p);
      sd[p] = {$urandom, $urandom};
      ss[p] = 8'($urandom);
      su[p] = {1'(p), 31'($urandom), $urandom, $urandom, $urandom};
      sl[p] = (bidx[p] == curlen[p] - 1);
      sv[p] = 1'b1;
   endtask

   // Advance a source after a possible handshake; valid is held until taken.
   task automatic src_step(input int p, input logic acc);
      if (acc) begin
         sv[p] = 1'b0;
         if (sl[p]) begin
            bidx[p] = 0;
            npkts[p]--;
            gap[p] = pick_gap(p);
         end else begin
            bidx[p]++;
            gap[p] = (bidx[p] == fga[p]) ? fgl[p] : pick_gap(p);
         end
      end
      if (!sv[p]) begin
         if (gap[p] > 0)
            gap[p]--;
         else if (en[p] != 0 && (bidx[p] > 0 || npkts[p] > 0)) begin
            if (bidx[p] == 0)
               curlen[p] = (plen[p] > 0) ? plen[p] : $urandom_range(1, 6);
            new_beat(p);
         end
      end
   endtask

   task automatic score();
      int p;
      int depth;
      logic [200:0] e;
      p = int'(m_tuser[127]);
      depth = (p == 0) ? qa.size() : qd.size();
      if (in_pkt)
         chk("no_interleave", p, cur_p);
      chk("sb_depth", depth > 0, 1);
      if (depth > 0) begin
         if (p == 0)
            e = qa.pop_front();
         else
            e = qd.pop_front();
         chk("beat", out_vec, e);
      end
      if (gap_chk) begin
         if (in_pkt)
            chk("back_to_back", cyc - prev_xfer, 1);
         else if (last_end >= 0)
            chk("one_bubble", cyc - last_end, 2);
      end
      prev_xfer = cyc;
      tot_beats++;
      if (m_tlast) begin
         in_pkt = 1'b0;
         pkt_beats = 0;
         out_order.push_back(p);
         sb_pkts[p]++;
         last_end = cyc;
      end else begin
         in_pkt = 1'b1;
         pkt_beats++;
         cur_p = p;
      end
   endtask

   // One clock: snapshot the handshakes that the next rising edge will see,
   // check the stream rules, then update stimulus on the falling edge.
   task automatic cycle();
      #1;
      hs_a = sv[0] && a_rdy;
      hs_d = sv[1] && d_rdy;
      hs_m = m_tvalid && m_tready;
      chk("rdy_exclusive", a_rdy && d_rdy, 0);
      if (m_tvalid && !m_tready)
         chk("rdy_when_stalled", {a_rdy, d_rdy}, 0);
      if (stalled_prev)
         chk("stall_hold", {m_tvalid, out_vec}, {1'b1, prev_out});
      if (t5_mode && bidx[0] > 0)
         chk("t5_d_blocked", d_rdy, 0);
      if (hs_a)
         qa.push_back({sl[0], su[0], ss[0], sd[0]});
      if (hs_d)
         qd.push_back({sl[1], su[1], ss[1], sd[1]});
      if (hs_m)
         score();
      stalled_prev = m_tvalid && !m_tready;
      prev_out = out_vec;
      @(negedge clk);
      cyc++;
      src_step(0, hs_a);
      src_step(1, hs_d);
      case (tr_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = !m_tready;
         default: m_tready = ($urandom_range(0, 99) < 60);
      endcase
   endtask

   function automatic bit done();
      return npkts[0] == 0 && npkts[1] == 0 && bidx[0] == 0 &&
             bidx[1] == 0 && !sv[0] && !sv[1] && qa.size() == 0 &&
             qd.size() == 0 && !m_tvalid;
   endfunction

   task automatic run(input int lim, input string tag);
      int n;
      n = 0;
      while (!done() && n < lim) begin
         cycle();
         n++;
      end
      chk(tag, done(), 1);
   endtask

   task automatic do_reset();
      arst = 1'b1;
      m_tready = 1'b0;
      tr_mode = 0;
      for (int p = 0; p < 2; p++) begin
         sv[p] = 1'b0;
         sd[p] = '0;
         ss[p] = '0;
         su[p] = '0;
         sl[p] = 1'b0;
         en[p] = 0;
         npkts[p] = 0;
         plen[p] = 0;
         bidx[p] = 0;
         curlen[p] = 1;
         gap[p] = 0;
         vpct[p] = 100;
         fga[p] = -1;
         fgl[p] = 0;
         sb_pkts[p] = 0;
      end
      qa.delete();
      qd.delete();
      out_order.delete();
      tot_beats = 0;
      pkt_beats = 0;
      in_pkt = 1'b0;
      cur_p = 0;
      last_end = -1;
      prev_xfer = 0;
      gap_chk = 1'b0;
      t5_mode = 1'b0;
      stalled_prev = 1'b0;
      prev_out = '0;
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_cnt_a"}, cnt_a, STATS ? sb_pkts[0] : 0);
      chk({tag, "_cnt_d"}, cnt_d, STATS ? sb_pkts[1] : 0);
   endtask

   initial begin
      bit found;

      // Reset release, no traffic: everything quiet for 10 cycles.
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_idle", {m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser,
                          a_rdy, d_rdy}, 0);
         chk_counters("rst");
      end

      // A sends 0x01..0x04, downstream always ready.
      sv[0] = 1'b1;
      sd[0] = 64'h1;
      ss[0] = 8'hff;
      su[0] = '0;
      sl[0] = 1'b0;
      #1 chk("t2_idle_rdy", {a_rdy, d_rdy}, 0);
      @(negedge clk);
      chk("t2_grant", {a_rdy, d_rdy}, 2'b10);
      chk("t2_latency", m_tvalid, 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("t2_beat", {m_tvalid, m_tlast, m_tdata},
             {1'b1, 1'(i == 4), 64'(i)});
         if (i < 4) begin
            sd[0] = 64'(i + 1);
            sl[0] = (i == 3);
         end else begin
            sv[0] = 1'b0;
            sl[0] = 1'b0;
         end
      end
      @(negedge clk);
      chk("t2_drain", m_tvalid, 0);
      chk("t2_cnt_a", cnt_a, STATS ? 1 : 0);

      // Both ports continuously offer 3-beat packets.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         en[p] = 1;
         plen[p] = 3;
         npkts[p] = 2;
      end
      gap_chk = 1'b1;
      m_tready = 1'b1;
      src_step(0, 1'b0);
      src_step(1, 1'b0);
      run(200, "t3_done");
      chk("t3_npkts", out_order.size(), 4);
      if (out_order.size() == 4)
         chk("t3_order", {1'(out_order[0]), 1'(out_order[1]),
                          1'(out_order[2]), 1'(out_order[3])}, 4'b0101);
      chk_counters("t3");

      // D 5-beat packet under alternating backpressure.
      do_reset();
      en[1] = 1;
      plen[1] = 5;
      npkts[1] = 1;
      tr_mode = 1;
      m_tready = 1'b1;
      src_step(1, 1'b0);
      run(100, "t4_done");
      chk("t4_beats", tot_beats, 5);
      chk("t4_pkts", sb_pkts[1], 1);

      // Granted A pauses 3 cycles mid-packet while D waits.
      do_reset();
      en[0] = 1;
      en[1] = 1;
      plen[0] = 4;
      plen[1] = 2;
      npkts[0] = 1;
      npkts[1] = 1;
      fga[0] = 2;
      fgl[0] = 3;
      t5_mode = 1'b1;
      m_tready = 1'b1;
      src_step(0, 1'b0);
      src_step(1, 1'b0);
      run(100, "t5_done");
      chk("t5_npkts", out_order.size(), 2);
      if (out_order.size() == 2)
         chk("t5_order", {1'(out_order[0]), 1'(out_order[1])}, 2'b01);

      // Reset while beat 2 of an A packet sits on the output.
      do_reset();
      en[0] = 1;
      plen[0] = 4;
      npkts[0] = 1;
      m_tready = 1'b1;
      src_step(0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = m_tvalid && in_pkt && pkt_beats == 1;
      end
      chk("t6_reach_beat2", found, 1);
      arst = 1'b1;
      #1 chk("t6_async_clear", {m_tvalid, out_vec, a_rdy, d_rdy}, 0);
      do_reset();
      en[0] = 1;
      en[1] = 1;
      plen[0] = 1;
      plen[1] = 1;
      npkts[0] = 1;
      npkts[1] = 1;
      m_tready = 1'b1;
      src_step(0, 1'b0);
      src_step(1, 1'b0);
      cycle();
      chk("t6_prefers_a", {a_rdy, d_rdy}, 2'b10);
      run(50, "t6_done");
      chk("t6_npkts", out_order.size(), 2);
      if (out_order.size() == 2)
         chk("t6_order", {1'(out_order[0]), 1'(out_order[1])}, 2'b01);
      chk_counters("t6");

      // Random lengths, gaps and backpressure on both ports.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         en[p] = 1;
         npkts[p] = 25;
         vpct[p] = 70;
      end
      tr_mode = 2;
      m_tready = 1'b1;
      src_step(0, 1'b0);
      src_step(1, 1'b0);
      run(4000, "rand_done");
      chk("rand_pkts_a", sb_pkts[0], 25);
      chk("rand_pkts_d", sb_pkts[1], 25);
      chk_counters("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
